// File: rtl/sqr_iter.sv
// Iterative squarer: consumes DIGIT bits of the magnitude per cycle.
// Signed operands are squared through their magnitude, so p_o is unsigned.
module sqr_iter #(
  parameter int BW    = 8,
  parameter int DIGIT = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [BW-1:0]   x_i,
  input  logic            sgn_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [2*BW-1:0] p_o
);

  localparam int N  = BW / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic [BW-1:0]   mr;
  logic [2*BW-1:0] mc;
  logic [2*BW-1:0] acc;
  logic [BW-1:0]   mag;
  logic [2*BW-1:0] pp;
  logic [2*BW-1:0] acc_nxt;

  // mr walks the multiplier digits, mc carries M pre-shifted by k*DIGIT
  always_comb begin
    mag = x_i;
    if (sgn_i && x_i[BW-1])
      mag = BW'(0) - x_i;
    pp      = mc * (2*BW)'(mr[DIGIT-1:0]);
    acc_nxt = acc + pp;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      p_o         <= '0;
      acc         <= '0;
      k           <= '0;
      mr          <= '0;
      mc          <= '0;
    end else if (clr_i) begin
      state       <= IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      acc         <= '0;
      k           <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid_i) begin
            mr         <= mag;
            mc         <= {{BW{1'b0}}, mag};
            acc        <= '0;
            k          <= '0;
            in_ready_o <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          mr  <= mr >> DIGIT;
          mc  <= mc << DIGIT;
          k   <= k + KW'(1);
          if (k == KW'(N - 1)) begin
            p_o         <= acc_nxt;
            out_valid_o <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sqr_iter.md
SQR_ITER -- requirements
Module: sqr_iter

Interface
REQ-001 SHALL have parameter BW, default 8: operand width; legal BW >= 2.
REQ-002 SHALL have parameter DIGIT, default 2: operand bits consumed per iteration; legal 1 <= DIGIT <= BW, BW mod DIGIT == 0; N = BW/DIGIT.
REQ-003 SHALL have port clk_i, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port clr_i, input, 1: synchronous abort, active-high.
REQ-006 SHALL have port in_valid_i, input, 1: operand valid.
REQ-007 SHALL have port in_ready_o, output, 1: block can accept an operand.
REQ-008 SHALL have port x_i, input, BW: operand.
REQ-009 SHALL have port sgn_i, input, 1: 1 = x_i two's-complement signed, 0 = unsigned; sampled with x_i.
REQ-010 SHALL have port out_valid_o, output, 1: result valid.
REQ-011 SHALL have port out_ready_i, input, 1: consumer accepts result.
REQ-012 SHALL have port p_o, output, 2*BW: square, always non-negative, unsigned interpretation.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-014 SHALL drive in_ready_o = 1 only in IDLE and out_valid_o = 1 only in DONE.
REQ-015 SHALL accept an operand on a rising edge where in_valid_i && in_ready_o, latching x_i and sgn_i and entering BUSY.
REQ-016 SHALL form magnitude M on accept: sgn_i=1 and x_i[BW-1]=1 -> M = -x_i as BW-bit unsigned (M = 2^(BW-1) for the most negative input); otherwise M = x_i.
REQ-017 SHALL clear accumulator and iteration counter k on accept.
REQ-018 SHALL, per BUSY cycle, add (M * M[k*DIGIT +: DIGIT]) << (k*DIGIT) to the 2*BW-bit accumulator and increment k.
REQ-019 SHALL leave BUSY for DONE on the edge completing iteration k = N-1; BUSY lasts exactly N cycles.
REQ-020 SHALL assert out_valid_o after edge E0+N, where E0 is the accept edge (latency N cycles to valid).
REQ-021 SHALL produce p_o = M*M exactly, equal to X*X for signed and unsigned interpretations; no overflow, no truncation.
REQ-022 SHALL hold p_o and out_valid_o stable in DONE until out_valid_o && out_ready_i, then return to IDLE on that edge.
REQ-023 SHALL keep p_o at its last result after the output handshake until the next result; p_o is only meaningful while out_valid_o = 1.
REQ-024 SHALL not accept input in BUSY or DONE; in_valid_i there is ignored and x_i/sgn_i changes have no effect.
REQ-025 SHALL permit out_ready_i held high before DONE; handshake completes on first DONE cycle.
REQ-026 SHALL, when clr_i = 1 on an edge, go to IDLE from any state, discard the operation, clear k; clr_i overrides in_valid_i and out_ready_i on the same edge; no result is emitted.
REQ-027 SHALL sustain throughput of one square per N+2 cycles with in_valid_i and out_ready_i held high.

Reset
REQ-028 SHALL, while rst_i = 1, immediately force state IDLE, in_ready_o = 1, out_valid_o = 0, p_o = 0, accumulator = 0, k = 0.
REQ-029 SHALL abort any in-flight operation on rst_i without emitting a result; first edge after deassertion may accept an operand.

Verification
REQ-030 SHALL cover BW=8, DIGIT=2, sgn_i=1, x_i=0x80 -> out_valid_o after 4 cycles, p_o=0x4000.
REQ-031 SHALL cover sgn_i=1, x_i=0xFF -> p_o=0x0001; sgn_i=0, x_i=0xFF -> p_o=0xFE01; x_i=0x00 -> p_o=0x0000.
REQ-032 SHALL cover backpressure: out_ready_i=0 for 10 cycles in DONE -> out_valid_o and p_o stable, in_ready_o=0, in_valid_i ignored; release -> IDLE next edge.
REQ-033 SHALL cover clr_i in 2nd BUSY cycle -> IDLE next edge, no out_valid_o; next operand x_i=0x07 unsigned -> p_o=0x0031.
REQ-034 SHALL cover rst_i asserted mid-BUSY and mid-DONE -> outputs immediately at reset values, no result emitted.
REQ-035 SHALL cover exhaustive x_i both modes for BW=8 at DIGIT in {1,2,4,8} with random backpressure, compared to a golden X*X model.
